// File: rtl/stb_pkg.sv
// Store buffer shared types.
//   stb_entry_t  : one buffered store {valid, word_addr, data, byte_en}
//   stb_state_e  : drain FSM encodings (IDLE, DRAIN)
//   be_mask()    : expand a byte-enable vector to a bit mask
// Entry widths are fixed by STB_AW/STB_DW; the top's AW/DW parameters
// default to these and must stay equal to them.
package stb_pkg;

    localparam int STB_AW       = 32;
    localparam int STB_DW       = 32;
    localparam int STB_BW       = STB_DW / 8;
    localparam int STB_WORD_LSB = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } stb_state_e;

    typedef struct packed {
        logic                           valid;
        logic [STB_AW-1:STB_WORD_LSB]   word_addr;
        logic [STB_DW-1:0]              data;
        logic [STB_BW-1:0]              byte_en;
    } stb_entry_t;

    function automatic logic [STB_DW-1:0] be_mask(input logic [STB_BW-1:0] be);
        logic [STB_DW-1:0] m;
        m = '0;
        for (int i = 0; i < STB_BW; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

endpackage

// File: rtl/stb_match_unit.sv
// Load-vs-buffer compare for the store buffer.
//   ent     in  : buffer entries (FIFO order starts at head)
//   head    in  : index of the oldest entry
//   ld_word in  : load word address
//   ld_be   in  : load byte lanes needed
//   hit     out : youngest matching entry covers every needed lane
//   partial out : youngest matching entry misses at least one needed lane
//   data    out : youngest match data masked to ld_be (0 unless hit)
module stb_match_unit
    import stb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  stb_entry_t                      ent [DEPTH],
    input  logic [PW-1:0]                   head,
    input  logic [STB_AW-1:STB_WORD_LSB]    ld_word,
    input  logic [STB_BW-1:0]               ld_be,
    output logic                            hit,
    output logic                            partial,
    output logic [STB_DW-1:0]               data
);

    logic          match;
    stb_entry_t    sel;
    logic [PW-1:0] idx;
    logic          covered;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        match = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (ent[idx].valid && ent[idx].word_addr == ld_word) begin
                match = 1'b1;
                sel   = ent[idx];
            end
        end
    end

    assign covered = (sel.byte_en & ld_be) == ld_be;
    assign hit     = match && covered;
    assign partial = match && !covered;
    assign data    = hit ? (sel.data & be_mask(ld_be)) : '0;

endmodule

// File: rtl/store_buffer_fwd_unit.sv
// MEM-stage store buffer with load forwarding.
// Stores enter a DEPTH-entry FIFO and drain to data memory while the port
// is free; loads to a buffered word are served from the youngest entry.
//   CLK, RESET(async, active low)
//   MEM_WRITE/MEM_READ/MEM_ADDR/MEM_WDATA/MEM_BYTE_EN : MEM-stage request
//   FWD_HIT/FWD_DATA : load served from buffer this cycle
//   STALL            : hold MEM stage
//   DM_WRITE/DM_ADDR/DM_WDATA/DM_BYTE_EN, DM_BUSYWAIT : data memory write port
// Build option: STB_COALESCE_EN merges a store into the youngest entry when
// it hits the same word and that entry is not the one being written out.
module store_buffer_fwd_unit
    import stb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = STB_AW,
    parameter int DW    = STB_DW
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            MEM_WRITE,
    input  logic            MEM_READ,
    input  logic [AW-1:0]   MEM_ADDR,
    input  logic [DW-1:0]   MEM_WDATA,
    input  logic [DW/8-1:0] MEM_BYTE_EN,
    output logic            FWD_HIT,
    output logic [DW-1:0]   FWD_DATA,
    output logic            STALL,
    output logic            DM_WRITE,
    output logic [AW-1:0]   DM_ADDR,
    output logic [DW-1:0]   DM_WDATA,
    output logic [DW/8-1:0] DM_BYTE_EN,
    input  logic            DM_BUSYWAIT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    stb_entry_t    ent_q [DEPTH];
    stb_entry_t    ent_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    stb_state_e    state_q, state_d;

    logic          ld_hit, ld_partial;
    logic [DW-1:0] ld_data;
    logic          full, retire, enq, merge, port_req_ld;
    stb_entry_t    head_ent;
    logic          unused_byte_offset;

    // Byte offset plays no part in word compare or storage.
    assign unused_byte_offset = ^MEM_ADDR[STB_WORD_LSB-1:0];

    stb_match_unit #(.DEPTH(DEPTH)) u_match (
        .ent     (ent_q),
        .head    (head_q),
        .ld_word (MEM_ADDR[AW-1:STB_WORD_LSB]),
        .ld_be   (MEM_BYTE_EN),
        .hit     (ld_hit),
        .partial (ld_partial),
        .data    (ld_data)
    );

`ifdef STB_COALESCE_EN
    logic [PW-1:0] young;
    assign young = tail_q - PW'(1);
    // Never merge into the head while it is on the memory port.
    assign merge = MEM_WRITE && count_q != '0
                && ent_q[young].word_addr == MEM_ADDR[AW-1:STB_WORD_LSB]
                && !(state_q == DRAIN && young == head_q);
`else
    assign merge = 1'b0;
`endif

    assign full        = count_q == CW'(DEPTH);
    assign retire      = state_q == DRAIN && !DM_BUSYWAIT;
    // Full buffer still accepts a store on the edge that frees the head slot.
    assign enq         = MEM_WRITE && !merge && (!full || retire);
    // A load needs the port only on a clean miss; hits and partials do not,
    // so a partial-stalled load lets the drain make progress.
    assign port_req_ld = MEM_READ && !ld_hit && !ld_partial;

    assign FWD_HIT  = MEM_READ && ld_hit;
    assign FWD_DATA = FWD_HIT ? ld_data : '0;
    assign STALL    = (MEM_WRITE && !merge && full && !retire)
                   || (MEM_READ && (ld_partial || (!ld_hit && state_q == DRAIN)));

    assign head_ent   = ent_q[head_q];
    assign DM_WRITE   = state_q == DRAIN;
    assign DM_ADDR    = DM_WRITE ? {head_ent.word_addr, {STB_WORD_LSB{1'b0}}} : '0;
    assign DM_WDATA   = DM_WRITE ? head_ent.data : '0;
    assign DM_BYTE_EN = DM_WRITE ? head_ent.byte_en : '0;

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        state_d = state_q;

        case (state_q)
            IDLE:    if (count_q != '0 && !port_req_ld) state_d = DRAIN;
            DRAIN:   if (!DM_BUSYWAIT) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Retire before enqueue: when full, both touch the same slot.
        if (retire) begin
            ent_d[head_q].valid = 1'b0;
            head_d = head_q + PW'(1);
        end
`ifdef STB_COALESCE_EN
        if (merge) begin
            ent_d[young].data    = (ent_q[young].data & ~be_mask(MEM_BYTE_EN))
                                 | (MEM_WDATA & be_mask(MEM_BYTE_EN));
            ent_d[young].byte_en = ent_q[young].byte_en | MEM_BYTE_EN;
        end
`endif
        if (enq) begin
            ent_d[tail_q].valid     = 1'b1;
            ent_d[tail_q].word_addr = MEM_ADDR[AW-1:STB_WORD_LSB];
            ent_d[tail_q].data      = MEM_WDATA;
            ent_d[tail_q].byte_en   = MEM_BYTE_EN;
            tail_d = tail_q + PW'(1);
        end

        count_d = count_q + CW'(enq) - CW'(retire);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_store_buffer_fwd_unit.sv
// Directed bench for store_buffer_fwd_unit (DEPTH=4). Inputs change on the
// falling edge; outputs are checked 1ns later. Memory writes are logged on
// cycles with DM_WRITE && !DM_BUSYWAIT. Define STB_COALESCE_EN for the
// coalescing build.
module tb_store_buffer_fwd_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_WRITE, MEM_READ;
    logic [31:0] MEM_ADDR, MEM_WDATA;
    logic [3:0]  MEM_BYTE_EN;
    logic        FWD_HIT, STALL, DM_WRITE, DM_BUSYWAIT;
    logic [31:0] FWD_DATA, DM_ADDR, DM_WDATA;
    logic [3:0]  DM_BYTE_EN;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    always #5 CLK = ~CLK;

    store_buffer_fwd_unit #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .MEM_WRITE   (MEM_WRITE),
        .MEM_READ    (MEM_READ),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_BYTE_EN (MEM_BYTE_EN),
        .FWD_HIT     (FWD_HIT),
        .FWD_DATA    (FWD_DATA),
        .STALL       (STALL),
        .DM_WRITE    (DM_WRITE),
        .DM_ADDR     (DM_ADDR),
        .DM_WDATA    (DM_WDATA),
        .DM_BYTE_EN  (DM_BYTE_EN),
        .DM_BUSYWAIT (DM_BUSYWAIT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            $error("%s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic busy);
        @(negedge CLK);
        MEM_WRITE   = w;
        MEM_READ    = r;
        MEM_ADDR    = a;
        MEM_WDATA   = d;
        MEM_BYTE_EN = be;
        DM_BUSYWAIT = busy;
        #1;
        if (DM_WRITE && !DM_BUSYWAIT) begin
            log_addr.push_back(DM_ADDR);
            log_data.push_back(DM_WDATA);
        end
    endtask

    task automatic idle(input logic busy);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, busy);
    endtask

    // Run the port free until n writes are logged, bounded by a cycle budget.
    task automatic drain(input int n);
        int cyc = 0;
        while (log_addr.size() < n && cyc < 40) begin
            idle(1'b0);
            cyc++;
        end
        chk("drain_count", 32'(log_addr.size()), 32'(n));
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        RESET = 1'b1;
        MEM_WRITE = 1'b0; MEM_READ = 1'b0; MEM_ADDR = '0; MEM_WDATA = '0;
        MEM_BYTE_EN = '0; DM_BUSYWAIT = 1'b0;
        #1 RESET = 1'b0;
        #1;
        chk("rst_fwd_hit",  32'(FWD_HIT),    32'h0);
        chk("rst_fwd_data", FWD_DATA,        32'h0);
        chk("rst_stall",    32'(STALL),      32'h0);
        chk("rst_dm_write", 32'(DM_WRITE),   32'h0);
        chk("rst_dm_addr",  DM_ADDR,         32'h0);
        chk("rst_dm_wdata", DM_WDATA,        32'h0);
        chk("rst_dm_be",    32'(DM_BYTE_EN), 32'h0);
        @(negedge CLK);
        RESET = 1'b1;

        // Full-word store then load: forwarded.
        step(1'b1, 1'b0, 32'h1000, 32'hDEADBEEF, 4'hF, 1'b1);
        chk("t1_store_stall", 32'(STALL), 32'h0);
        step(1'b0, 1'b1, 32'h1000, 32'h0, 4'hF, 1'b1);
        chk("t1_fwd_hit",   32'(FWD_HIT), 32'h1);
        chk("t1_fwd_data",  FWD_DATA,     32'hDEADBEEF);
        chk("t1_ld_stall",  32'(STALL),   32'h0);
        idle(1'b1);
        chk("t1_dm_write",  32'(DM_WRITE), 32'h1);
        chk("t1_dm_addr",   DM_ADDR,       32'h1000);
        chk("t1_dm_wdata",  DM_WDATA,      32'hDEADBEEF);
        drain(1);
        chk("t1_mem_data",  log_data[0],   32'hDEADBEEF);
        clear_log();

        // Partial coverage: stall until retired, then plain miss.
        step(1'b1, 1'b0, 32'h2000, 32'h000000AB, 4'h1, 1'b1);
        step(1'b0, 1'b1, 32'h2000, 32'h0, 4'hF, 1'b1);
        chk("t2_partial_stall", 32'(STALL),   32'h1);
        chk("t2_partial_hit",   32'(FWD_HIT), 32'h0);
        step(1'b0, 1'b1, 32'h2000, 32'h0, 4'hF, 1'b1);
        chk("t2_stall_drain",   32'(STALL),   32'h1);
        step(1'b0, 1'b1, 32'h2000, 32'h0, 4'hF, 1'b0);
        chk("t2_stall_retire",  32'(STALL),   32'h1);
        step(1'b0, 1'b1, 32'h2000, 32'h0, 4'hF, 1'b1);
        chk("t2_after_stall",   32'(STALL),   32'h0);
        chk("t2_after_hit",     32'(FWD_HIT), 32'h0);
        chk("t2_mem_addr",      log_addr[0],  32'h2000);
        clear_log();

        // Fill to DEPTH, stall the 5th, then retire+enqueue on one edge.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'(32'h100 + 4*i), 32'(i + 1), 4'hF, 1'b1);
            chk($sformatf("t3_fill%0d_stall", i), 32'(STALL), 32'h0);
        end
        step(1'b1, 1'b0, 32'h110, 32'd5, 4'hF, 1'b1);
        chk("t3_full_stall",  32'(STALL), 32'h1);
        step(1'b1, 1'b0, 32'h110, 32'd5, 4'hF, 1'b0);
        chk("t3_retire_stall", 32'(STALL), 32'h0);
        chk("t3_retire_addr",  DM_ADDR,    32'h100);
        step(1'b1, 1'b0, 32'h114, 32'd6, 4'hF, 1'b1);
        chk("t3_still_full",  32'(STALL), 32'h1);
        step(1'b0, 1'b1, 32'h110, 32'h0, 4'hF, 1'b1);
        chk("t3_wrap_hit",    32'(FWD_HIT), 32'h1);
        chk("t3_wrap_data",   FWD_DATA,     32'd5);
        drain(5);
        for (int i = 0; i < 5; i++) begin
            if (i < log_addr.size()) begin
                chk($sformatf("t3_order%0d_addr", i), log_addr[i], 32'(32'h100 + 4*i));
                chk($sformatf("t3_order%0d_data", i), log_data[i], 32'(i + 1));
            end
        end
        clear_log();

        // Same word stored twice: youngest forwards, memory order preserved.
        step(1'b1, 1'b0, 32'h3000, 32'd1, 4'hF, 1'b1);
        step(1'b1, 1'b0, 32'h3000, 32'd2, 4'hF, 1'b1);
        step(1'b0, 1'b1, 32'h3000, 32'h0, 4'hF, 1'b1);
        chk("t4_fwd_hit",  32'(FWD_HIT), 32'h1);
        chk("t4_fwd_data", FWD_DATA,     32'd2);
`ifdef STB_COALESCE_EN
        drain(1);
        chk("t4_mem_single", log_data[0], 32'd2);
`else
        drain(2);
        chk("t4_mem_first",  log_data[0], 32'd1);
        if (log_data.size() > 1) chk("t4_mem_second", log_data[1], 32'd2);
`endif
        clear_log();

        // Asynchronous reset in the middle of a drain.
        step(1'b1, 1'b0, 32'h5000, 32'h55, 4'hF, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("t5_in_drain", 32'(DM_WRITE), 32'h1);
        #1 RESET = 1'b0;
        MEM_READ = 1'b1; MEM_ADDR = 32'h5000; MEM_BYTE_EN = 4'hF;
        #1;
        chk("t5_rst_dm_write", 32'(DM_WRITE), 32'h0);
        chk("t5_rst_fwd_hit",  32'(FWD_HIT),  32'h0);
        chk("t5_rst_stall",    32'(STALL),    32'h0);
        chk("t5_rst_dm_addr",  DM_ADDR,       32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        step(1'b0, 1'b1, 32'h5000, 32'h0, 4'hF, 1'b1);
        chk("t5_post_hit",   32'(FWD_HIT), 32'h0);
        chk("t5_post_stall", 32'(STALL),   32'h0);

`ifdef STB_COALESCE_EN
        // Two lanes of one word merge into a single entry and write.
        clear_log();
        step(1'b1, 1'b0, 32'h4000, 32'h00000011, 4'h1, 1'b1);
        step(1'b1, 1'b0, 32'h4000, 32'h00002200, 4'h2, 1'b1);
        chk("t6_merge_stall", 32'(STALL), 32'h0);
        step(1'b0, 1'b1, 32'h4000, 32'h0, 4'h3, 1'b1);
        chk("t6_fwd_hit",  32'(FWD_HIT), 32'h1);
        chk("t6_fwd_data", FWD_DATA,     32'h00002211);
        idle(1'b1);
        chk("t6_dm_wdata", DM_WDATA,        32'h00002211);
        chk("t6_dm_be",    32'(DM_BYTE_EN), 32'h3);
        drain(1);
        repeat (3) idle(1'b0);
        chk("t6_single_write", 32'(log_addr.size()), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
